bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and control-line router for the shared serial bus. Takes `B_REQ` from each bus master, issues a one-hot `B_GRANT`, and forwards the granted master's `B_UTIL`/`B_RW` to the slave side. It returns slave `B_ACK` only to the granted master and revokes a grant that is never used. The serial data wire `B_BUS` is a shared tri-state net and does not pass through this block.

## Interface
- `N_MASTERS`, default 2: number of requesters, 2..8.
- `TIMEOUT`, default 32: cycles a granted master may go without asserting `UTIL` before the grant is revoked, ≥2.
- `CLK` in 1: clock, all state on rising edge.
- `RSTN` in 1: reset, asynchronous, active-high.
- `M_REQ` in N_MASTERS: per-master bus request (master `B_REQ`), level, held for the whole transaction.
- `M_UTIL` in N_MASTERS: per-master bus-utilisation flag (master `B_UTIL`).
- `M_RW` in N_MASTERS: per-master direction (master `B_RW`, 1 = write).
- `M_GRANT` out N_MASTERS: one-hot grant, registered.
- `M_ACK` out N_MASTERS: `S_ACK` gated to the granted master only.
- `S_UTIL` out 1: `M_UTIL` of the granted master, 0 when no grant.
- `S_RW` out 1: `M_RW` of the granted master, 0 when no grant.
- `S_ACK` in 1: wired-OR acknowledge from slaves.
- `OWNER` out max(1,$clog2(N_MASTERS)): index of current or last owner.
- `BUS_BUSY` out 1: 1 while the owner has asserted `UTIL` at least once in this tenure.
- `TIMEOUT_EVT` out 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states:
  - **IDLE**: no grant; arbitrate when any `M_REQ` is high.
  - **GRANTED**: a grant has been issued and the owner has not yet used the bus.
  - **BUSY**: the owner has asserted `UTIL`.
  - **RELEASE**: one dead cycle with `M_GRANT` = 0.
- Arbitration happens only in IDLE and RELEASE.
  - The winner is the first requester found searching from `last_owner+1` upward, with wrap-around.
  - The `last_owner` pointer resets to N_MASTERS-1, so master 0 wins first after reset.
- IDLE/RELEASE with winner w at edge: `M_GRANT` ← one-hot(w), `OWNER` ← w, `last_owner` ← w, wait counter ← 0, go to GRANTED.
- RELEASE with no request: go to IDLE.
- GRANTED transitions, in priority order:
  - `M_REQ[owner]` = 0 → RELEASE.
  - `M_UTIL[owner]` = 1 → BUSY, `BUS_BUSY` ← 1.
  - counter = TIMEOUT-1 → RELEASE with `TIMEOUT_EVT` = 1.
  - otherwise counter+1. Counter width is $clog2(TIMEOUT+1) and it never wraps.
- BUSY: `M_REQ[owner]` = 0 → RELEASE. No preemption and no timeout in BUSY.
- Leaving to RELEASE clears `M_GRANT` and `BUS_BUSY` at that edge.
- Combinational routing:
  - `S_UTIL` = |(`M_UTIL` & `M_GRANT`).
  - `S_RW` = |(`M_RW` & `M_GRANT`).
  - `M_ACK` = `M_GRANT` & {N{`S_ACK`}}.
- Non-owner `UTIL`/`RW` are ignored and never reach the slave side.
- After a timeout the offender is `last_owner`, so other requesters are served first. If it is the sole requester it is re-granted after the RELEASE cycle.
- `M_REQ` of a non-owner dropping has no effect.

## Timing
- Reset values:
  - Outputs: `M_GRANT` = 0, `M_ACK` = 0, `S_UTIL` = 0, `S_RW` = 0, `OWNER` = 0, `BUS_BUSY` = 0, `TIMEOUT_EVT` = 0.
  - Internal state: FSM = IDLE, counter = 0.
- Grant latency: `M_REQ` high before edge k (bus idle) → `M_GRANT` high after edge k. This is one cycle.
- Release: owner `M_REQ` low before edge k → `M_GRANT` = 0 after edge k and stays 0 for ≥1 full cycle. The next grant appears after edge k+1 at the earliest.
- Back-to-back handover therefore costs exactly 2 cycles from REQ drop to the new grant.
- Timeout: grant issued at edge g with `UTIL` never high → `TIMEOUT_EVT` and grant removal at edge g+TIMEOUT.
- Owner `UTIL` high on the same edge that the counter reaches TIMEOUT-1: `UTIL` wins, go to BUSY, no timeout.
- Owner `REQ` low and `UTIL` high on the same edge: release wins.
- `RSTN` asserted mid-transaction: immediately (asynchronously) `M_GRANT` = 0 and routed outputs go to 0. On deassertion the pointer restarts at master 0.

## Test plan
- **Reset/first grant.** Assert `RSTN`, release it, then raise `M_REQ` = 2'b11 together → `M_GRANT` = 2'b01 one cycle later, `OWNER` = 0.
- **Round-robin handover.** Hold `M_REQ` = 2'b11; master 0 raises `UTIL`, then drops `REQ` → `M_GRANT` 01 → 00 (1 cycle) → 10. `S_UTIL`/`S_RW` track master 1 only.
- **ACK routing.** Master 1 granted; pulse `S_ACK` for 3 cycles while master 0 drives `UTIL` = 1 → `M_ACK` = 2'b10 for those 3 cycles and `S_UTIL` equals master 1's `UTIL`.
- **Timeout.** TIMEOUT = 32; master 0 requests and never drives `UTIL` → `TIMEOUT_EVT` pulse 32 cycles after the grant. Master 1 requesting is granted 1 cycle later; if master 1 is not requesting, master 0 is re-granted.
- **Simultaneous boundary.** Owner `UTIL` rises in the counter = TIMEOUT-1 cycle → no `TIMEOUT_EVT`, `BUS_BUSY` = 1.
- **Mid-transfer reset.** Master 1 in BUSY; assert `RSTN` for 1 cycle → `M_GRANT` = 0 immediately. With both requesting afterward, master 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Control-line bundle between bus masters, the arbiter and the slave side.
// The arbiter uses the slave modport; the master modport drives requests.
interface bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 2
);
  localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0] M_REQ;
  logic [N_MASTERS-1:0] M_UTIL;
  logic [N_MASTERS-1:0] M_RW;
  logic                 S_ACK;
  logic [N_MASTERS-1:0] M_GRANT;
  logic [N_MASTERS-1:0] M_ACK;
  logic                 S_UTIL;
  logic                 S_RW;
  logic [OW-1:0]        OWNER;
  logic                 BUS_BUSY;
  logic                 TIMEOUT_EVT;

  modport master (
    output M_REQ, M_UTIL, M_RW, S_ACK,
    input  M_GRANT, M_ACK, S_UTIL, S_RW, OWNER, BUS_BUSY, TIMEOUT_EVT
  );

  modport slave (
    input  M_REQ, M_UTIL, M_RW, S_ACK,
    output M_GRANT, M_ACK, S_UTIL, S_RW, OWNER, BUS_BUSY, TIMEOUT_EVT
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared serial bus: one-hot grant, control-line
// routing to the slave side, ACK return to the owner, revocation of unused grants.
module bus_arbiter #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 32
) (
  input logic          CLK,
  input logic          RSTN,
  bus_arbiter_if.slave bus
);
  localparam int unsigned OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_BUSY,
    ST_RELEASE
  } state_t;

  state_t               r_state, w_state;
  logic [N_MASTERS-1:0] r_grant, w_grant;
  logic [OW-1:0]        r_owner, w_owner;
  logic [OW-1:0]        r_last,  w_last;
  logic [CW-1:0]        r_cnt,   w_cnt;
  logic                 r_busy,  w_busy;
  logic                 r_tevt,  w_tevt;

  logic                 w_found;
  logic [OW-1:0]        w_win;

  // Round-robin search starting just after the last owner, with wrap-around
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= int'(N_MASTERS); k++) begin
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if (!w_found && bus.M_REQ[i] &&
            (((int'(r_last) + k) % int'(N_MASTERS)) == i)) begin
          w_found = 1'b1;
          w_win   = OW'(i);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= OW'(N_MASTERS - 1);
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_tevt  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_grant <= w_grant;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
      r_busy  <= w_busy;
      r_tevt  <= w_tevt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_owner = r_owner;
    w_last  = r_last;
    w_cnt   = r_cnt;
    w_busy  = r_busy;
    w_tevt  = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_found) begin
          w_state = ST_GRANTED;
          w_grant = N_MASTERS'(1) << w_win;
          w_owner = w_win;
          w_last  = w_win;
          w_cnt   = '0;
        end else begin
          w_state = ST_IDLE;
          w_grant = '0;
        end
      end

      // Release beats first use, which beats the timeout on the same edge
      ST_GRANTED: begin
        if (!bus.M_REQ[r_owner]) begin
          w_state = ST_RELEASE;
          w_grant = '0;
          w_busy  = 1'b0;
        end else if (bus.M_UTIL[r_owner]) begin
          w_state = ST_BUSY;
          w_busy  = 1'b1;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state = ST_RELEASE;
          w_grant = '0;
          w_busy  = 1'b0;
          w_tevt  = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end

      ST_BUSY: begin
        if (!bus.M_REQ[r_owner]) begin
          w_state = ST_RELEASE;
          w_grant = '0;
          w_busy  = 1'b0;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_grant = '0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign bus.M_GRANT     = r_grant;
  assign bus.OWNER       = r_owner;
  assign bus.BUS_BUSY    = r_busy;
  assign bus.TIMEOUT_EVT = r_tevt;

  // Only the owner's control lines reach the slaves, and ACK only returns to it
  assign bus.S_UTIL = |(bus.M_UTIL & r_grant);
  assign bus.S_RW   = |(bus.M_RW & r_grant);
  assign bus.M_ACK  = r_grant & {N_MASTERS{bus.S_ACK}};

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then a
// randomized run against a tenure-level reference model.
module tb_bus_arbiter;
  localparam int N  = 2;
  localparam int TO = 32;

  logic clk;
  logic rstn;

  bus_arbiter_if #(.N_MASTERS(N)) bus ();

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: who holds the bus, whether it was used, how long it waited
  bit m_granted;
  int m_owner;
  int m_ptr;
  bit m_used;
  int m_wait;
  bit m_tevt;

  task automatic model_step(input logic rst, input logic [N-1:0] rq,
                            input logic [N-1:0] ut);
    if (rst) begin
      m_granted = 0; m_owner = 0; m_ptr = N - 1;
      m_used = 0; m_wait = 0; m_tevt = 0;
      return;
    end
    m_tevt = 0;
    if (!m_granted) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (rq[c]) begin
          m_granted = 1; m_owner = c; m_ptr = c; m_used = 0; m_wait = 0;
          break;
        end
      end
    end else if (!rq[m_owner]) begin
      m_granted = 0; m_used = 0;
    end else if (!m_used) begin
      if (ut[m_owner]) m_used = 1;
      else if (m_wait == TO - 1) begin
        m_granted = 0; m_used = 0; m_tevt = 1;
      end else m_wait++;
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_granted) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic tick();
    logic rs;
    logic [N-1:0] rq, ut;
    rs = rstn; rq = bus.M_REQ; ut = bus.M_UTIL;
    @(posedge clk);
    model_step(rs, rq, ut);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] ut,
                       input logic [N-1:0] rw, input logic ack);
    bus.M_REQ = rq; bus.M_UTIL = ut; bus.M_RW = rw; bus.S_ACK = ack;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    tick(); tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b00 || bus.M_ACK !== 2'b00 || bus.S_UTIL !== 1'b0 ||
        bus.S_RW !== 1'b0 || bus.OWNER !== 1'b0 || bus.BUS_BUSY !== 1'b0 ||
        bus.TIMEOUT_EVT !== 1'b0) begin
      $display("FAIL reset: grant=%b ack=%b sutil=%b srw=%b owner=%0d busy=%b tevt=%b, expected all zero",
               bus.M_GRANT, bus.M_ACK, bus.S_UTIL, bus.S_RW, bus.OWNER,
               bus.BUS_BUSY, bus.TIMEOUT_EVT);
      n_fail++;
    end
    rstn = 1'b0;
    tick();
  endtask

  task automatic test_first_grant();
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b01 || bus.OWNER !== 1'b0) begin
      $display("FAIL first_grant: grant=%b owner=%0d, expected 01 owner 0",
               bus.M_GRANT, bus.OWNER);
      n_fail++;
    end
  endtask

  task automatic test_handover();
    drive(2'b11, 2'b01, 2'b01, 1'b0);
    tick();
    n_tests++;
    if (bus.BUS_BUSY !== 1'b1 || bus.S_UTIL !== 1'b1 || bus.S_RW !== 1'b1) begin
      $display("FAIL handover_busy: busy=%b sutil=%b srw=%b, expected 1 1 1",
               bus.BUS_BUSY, bus.S_UTIL, bus.S_RW);
      n_fail++;
    end
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b00 || bus.BUS_BUSY !== 1'b0) begin
      $display("FAIL handover_dead: grant=%b busy=%b, expected 00 0",
               bus.M_GRANT, bus.BUS_BUSY);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b10 || bus.OWNER !== 1'b1) begin
      $display("FAIL handover_new: grant=%b owner=%0d, expected 10 owner 1",
               bus.M_GRANT, bus.OWNER);
      n_fail++;
    end
    drive(2'b10, 2'b10, 2'b01, 1'b0);
    #1;
    n_tests++;
    if (bus.S_UTIL !== 1'b1 || bus.S_RW !== 1'b0) begin
      $display("FAIL route_owner_only: sutil=%b srw=%b, expected 1 0",
               bus.S_UTIL, bus.S_RW);
      n_fail++;
    end
    drive(2'b10, 2'b10, 2'b10, 1'b0);
    #1;
    n_tests++;
    if (bus.S_RW !== 1'b1) begin
      $display("FAIL route_rw: srw=%b, expected 1", bus.S_RW);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_ack_routing();
    drive(2'b10, 2'b01, 2'b00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (bus.M_ACK !== 2'b10 || bus.S_UTIL !== 1'b0) begin
        $display("FAIL ack_route[%0d]: ack=%b sutil=%b, expected 10 0",
                 c, bus.M_ACK, bus.S_UTIL);
        n_fail++;
      end
      tick();
    end
    bus.S_ACK = 1'b0;
    #1;
    n_tests++;
    if (bus.M_ACK !== 2'b00) begin
      $display("FAIL ack_idle: ack=%b, expected 00", bus.M_ACK);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    tick();
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b01) begin
      $display("FAIL timeout_grant: grant=%b, expected 01", bus.M_GRANT);
      n_fail++;
    end
    for (int c = 1; c < TO; c++) begin
      tick();
      n_tests++;
      if (bus.TIMEOUT_EVT !== 1'b0 || bus.M_GRANT !== 2'b01) begin
        $display("FAIL timeout_early[%0d]: tevt=%b grant=%b, expected 0 01",
                 c, bus.TIMEOUT_EVT, bus.M_GRANT);
        n_fail++;
      end
    end
    bus.M_REQ = 2'b11;
    tick();
    n_tests++;
    if (bus.TIMEOUT_EVT !== 1'b1 || bus.M_GRANT !== 2'b00) begin
      $display("FAIL timeout_evt: tevt=%b grant=%b, expected 1 00",
               bus.TIMEOUT_EVT, bus.M_GRANT);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b10 || bus.TIMEOUT_EVT !== 1'b0) begin
      $display("FAIL timeout_other: grant=%b tevt=%b, expected 10 0",
               bus.M_GRANT, bus.TIMEOUT_EVT);
      n_fail++;
    end
    bus.M_REQ = 2'b01;
    tick();
    tick();
    repeat (TO) tick();
    n_tests++;
    if (bus.TIMEOUT_EVT !== 1'b1) begin
      $display("FAIL timeout_sole_evt: tevt=%b, expected 1", bus.TIMEOUT_EVT);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b01) begin
      $display("FAIL timeout_regrant: grant=%b, expected 01", bus.M_GRANT);
      n_fail++;
    end
  endtask

  task automatic test_boundary();
    repeat (TO - 1) tick();
    bus.M_UTIL = 2'b01;
    tick();
    n_tests++;
    if (bus.TIMEOUT_EVT !== 1'b0 || bus.BUS_BUSY !== 1'b1 || bus.M_GRANT !== 2'b01) begin
      $display("FAIL boundary: tevt=%b busy=%b grant=%b, expected 0 1 01",
               bus.TIMEOUT_EVT, bus.BUS_BUSY, bus.M_GRANT);
      n_fail++;
    end
    bus.M_UTIL = 2'b00;
    repeat (TO + 8) tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b01 || bus.BUS_BUSY !== 1'b1) begin
      $display("FAIL busy_no_timeout: grant=%b busy=%b, expected 01 1",
               bus.M_GRANT, bus.BUS_BUSY);
      n_fail++;
    end
  endtask

  task automatic test_release_wins();
    bus.M_REQ = 2'b00;
    tick();
    bus.M_REQ = 2'b01;
    tick();
    drive(2'b00, 2'b01, 2'b00, 1'b0);
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b00 || bus.BUS_BUSY !== 1'b0) begin
      $display("FAIL release_wins: grant=%b busy=%b, expected 00 0",
               bus.M_GRANT, bus.BUS_BUSY);
      n_fail++;
    end
    bus.M_UTIL = 2'b00;
  endtask

  task automatic test_reset_mid();
    bus.M_REQ = 2'b10;
    tick();
    bus.M_UTIL = 2'b10;
    tick();
    bus.S_ACK = 1'b1;
    #3 rstn = 1'b1;
    #1;
    n_tests++;
    if (bus.M_GRANT !== 2'b00 || bus.M_ACK !== 2'b00 || bus.S_UTIL !== 1'b0 ||
        bus.BUS_BUSY !== 1'b0) begin
      $display("FAIL reset_mid: grant=%b ack=%b sutil=%b busy=%b, expected 00 00 0 0",
               bus.M_GRANT, bus.M_ACK, bus.S_UTIL, bus.BUS_BUSY);
      n_fail++;
    end
    tick();
    rstn = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 1'b0);
    tick();
    n_tests++;
    if (bus.M_GRANT !== 2'b01 || bus.OWNER !== 1'b0) begin
      $display("FAIL reset_restart: grant=%b owner=%0d, expected 01 owner 0",
               bus.M_GRANT, bus.OWNER);
      n_fail++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rq, ut, rw, eg;
    logic         ak;
    rstn = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    rstn = 1'b0;
    rq = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) rq[b] = ~rq[b];
        ut[b] = ($urandom_range(0, 19) == 0);
        rw[b] = 1'($urandom_range(0, 1));
      end
      ak = 1'($urandom_range(0, 1));
      drive(rq, ut, rw, ak);
      #1;
      eg = exp_grant();
      n_tests++;
      if (bus.M_GRANT !== eg || bus.OWNER !== 1'(m_owner) ||
          bus.BUS_BUSY !== (m_granted && m_used) || bus.TIMEOUT_EVT !== m_tevt ||
          bus.S_UTIL !== |(ut & eg) || bus.S_RW !== |(rw & eg) ||
          bus.M_ACK !== (eg & {N{ak}})) begin
        $display("FAIL random[%0d]: grant=%b/%b owner=%0d/%0d busy=%b/%b tevt=%b/%b sutil=%b/%b srw=%b/%b ack=%b/%b (got/exp)",
                 c, bus.M_GRANT, eg, bus.OWNER, m_owner, bus.BUS_BUSY,
                 (m_granted && m_used), bus.TIMEOUT_EVT, m_tevt,
                 bus.S_UTIL, |(ut & eg), bus.S_RW, |(rw & eg),
                 bus.M_ACK, (eg & {N{ak}}));
        n_fail++;
      end
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 1'b0);
    model_step(1'b1, '0, '0);
    test_reset();
    test_first_grant();
    test_handover();
    test_ack_routing();
    test_timeout();
    test_boundary();
    test_release_wins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
